// File: rtl/exec_stage_pipe.sv
// Execution stage: single-cycle ALU with registered result/store data/flags behind a valid/ready handshake.
// Define EXEC_MUL_EN to include the iterative shift-add multiplier (MUL); otherwise MUL decodes as illegal.
module exec_stage_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op_dec,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ans_ex,
    output logic [WIDTH-1:0] dm_data,
    output logic [3:0]       flag_ex,
    output logic             illegal,
    output logic             busy
);

    localparam int MSB = WIDTH - 1;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_AND   = 5'b00010;
    localparam logic [4:0] OP_OR    = 5'b00011;
    localparam logic [4:0] OP_XOR   = 5'b00100;
    localparam logic [4:0] OP_NOT   = 5'b00101;
    localparam logic [4:0] OP_SHL   = 5'b00110;
    localparam logic [4:0] OP_SHR   = 5'b00111;
    localparam logic [4:0] OP_SRA   = 5'b01000;
    localparam logic [4:0] OP_ADC   = 5'b01001;
    localparam logic [4:0] OP_PASS  = 5'b01010;
    localparam logic [4:0] OP_STORE = 5'b01011;
`ifdef EXEC_MUL_EN
    localparam logic [4:0] OP_MUL   = 5'b01100;
`endif

    typedef enum logic {S_IDLE, S_MULT} state_t;

    state_t state_q, state_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] ans_q, ans_d;
    logic [WIDTH-1:0] dm_q, dm_d;
    logic [3:0]       flag_q, flag_d;
    logic             ill_q, ill_d;

    logic             accept;
    logic             is_mul_op;
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;
    logic [3:0]       mul_flags;

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign ans_ex    = ans_q;
    assign dm_data   = dm_q;
    assign flag_ex   = flag_q;
    assign illegal   = ill_q;

    // ---------------- single-cycle ALU ----------------
    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   shl_ext, shr_ext, sra_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_upd, alu_ill;
    logic [3:0]       alu_flags;

    // One extra bit on the shift operands catches the last bit shifted out (0 when amt is 0).
    assign amt     = b[SHW-1:0];
    assign shl_ext = {1'b0, a} << amt;
    assign shr_ext = {a, 1'b0} >> amt;
    assign sra_ext = $signed({a, 1'b0}) >>> amt;

    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_upd = 1'b1;
        alu_ill = 1'b0;
        case (op_dec)
            OP_ADD: begin
                sum     = {1'b0, a} + {1'b0, b};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_ADC: begin
                sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, flag_q[1]};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_res = a - b;
                alu_c   = (a >= b);
                alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOT:  alu_res = ~a;
            OP_PASS: alu_res = b;
            OP_SHL: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            OP_SRA: begin
                alu_res = sra_ext[WIDTH:1];
                alu_c   = sra_ext[0];
            end
            OP_STORE: begin
                alu_res = a;
                alu_upd = 1'b0;
            end
            default: begin
                alu_upd = 1'b0;
                alu_ill = 1'b1;
            end
        endcase
        alu_flags = alu_upd ? {alu_res == '0, alu_res[MSB], alu_c, alu_v} : flag_q;
    end

    // ---------------- iterative multiplier ----------------
`ifdef EXEC_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q, acc_q, acc_step;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               mul_hi;

    assign is_mul_op = (op_dec == OP_MUL);
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    // The last step's sum is forwarded straight to the output registers.
    assign mul_done  = (state_q == S_MULT) && (cnt_q == CW'(1));
    assign mul_res   = acc_step[WIDTH-1:0];
    assign mul_hi    = |acc_step[2*WIDTH-1:WIDTH];
    assign mul_flags = {mul_res == '0, mul_res[MSB], mul_hi, mul_hi};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (accept && is_mul_op) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            acc_q    <= '0;
            mplier_q <= b;
            cnt_q    <= CW'(WIDTH);
        end else if (state_q == S_MULT) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
        end
    end
`else
    assign is_mul_op = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_res   = '0;
    assign mul_flags = '0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && is_mul_op) state_d = S_MULT;
            S_MULT: if (mul_done)            state_d = S_IDLE;
        endcase
    end

`ifdef EXEC_MUL_EN
    always_comb busy = (state_q == S_MULT);
`else
    assign busy = 1'b0;
`endif

    // ---------------- output registers ----------------
    // A new accept or MUL completion can only happen when the held result is free.
    always_comb begin
        out_valid_d = out_valid_q;
        ans_d       = ans_q;
        dm_d        = dm_q;
        flag_d      = flag_q;
        ill_d       = ill_q;
        if (accept) dm_d = b;
        if (accept && !is_mul_op) begin
            out_valid_d = 1'b1;
            ans_d       = alu_res;
            flag_d      = alu_flags;
            ill_d       = alu_ill;
        end else if (mul_done) begin
            out_valid_d = 1'b1;
            ans_d       = mul_res;
            flag_d      = mul_flags;
            ill_d       = 1'b0;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            ans_q       <= '0;
            dm_q        <= '0;
            flag_q      <= '0;
            ill_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            ans_q       <= ans_d;
            dm_q        <= dm_d;
            flag_q      <= flag_d;
            ill_q       <= ill_d;
        end
    end

endmodule

// File: tb/tb_exec_stage_pipe.sv
// Bench for exec_stage_pipe (WIDTH=8): vector table plus reset, back-pressure and multiply sequences.
module tb_exec_stage_pipe;

    localparam int W = 8;

    localparam logic [4:0] OP_ADD = 5'h00, OP_SUB = 5'h01, OP_AND = 5'h02, OP_OR = 5'h03;
    localparam logic [4:0] OP_XOR = 5'h04, OP_NOT = 5'h05, OP_SHL = 5'h06, OP_SHR = 5'h07;
    localparam logic [4:0] OP_SRA = 5'h08, OP_ADC = 5'h09, OP_PASS = 5'h0A, OP_STORE = 5'h0B;
    localparam logic [4:0] OP_MUL = 5'h0C, OP_BAD = 5'h1F;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready;
    logic [4:0]   op_dec;
    logic [W-1:0] a, b;
    logic         out_valid, out_ready;
    logic [W-1:0] ans_ex, dm_data;
    logic [3:0]   flag_ex;
    logic         illegal, busy;

    exec_stage_pipe #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_dec(op_dec), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .ans_ex(ans_ex), .dm_data(dm_data), .flag_ex(flag_ex), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] ans;
        logic [7:0] dm;
        logic [3:0] fl;
        logic       ill;
    } exp_t;

    typedef struct packed {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ans;
        logic [3:0] fl;
        logic       ill;
    } vec_t;

    exp_t sbq[$];
    exp_t me;
    int   n_cmp = 0;
    int   n_err = 0;
    int   busy_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: a result counts as delivered on a cycle with out_valid && out_ready.
    always @(negedge clk) begin
        if (!reset && busy) busy_cyc++;
        if (!reset && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got ans %0h, expected no result", ans_ex);
            end else begin
                me = sbq.pop_front();
                chk("res_ans",     32'(ans_ex),  32'(me.ans));
                chk("res_dm",      32'(dm_data), 32'(me.dm));
                chk("res_flags",   32'(flag_ex), 32'(me.fl));
                chk("res_illegal", 32'(illegal), 32'(me.ill));
            end
        end
    end

    // Presents one op and holds it until accepted; pushes its expectation at the accepting edge.
    task automatic send(input logic [4:0] o, input logic [7:0] x, input logic [7:0] y,
                        input exp_t e, input bit push);
        int w = 0;
        op_dec   = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready 0 for op %0h, expected 1", o);
        end
        @(posedge clk);
        if (push && in_ready) sbq.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
        chk({tag, "_ans"},       32'(ans_ex),    32'(0));
        chk({tag, "_dm"},        32'(dm_data),   32'(0));
        chk({tag, "_flags"},     32'(flag_ex),   32'(0));
        chk({tag, "_illegal"},   32'(illegal),   32'(0));
        chk({tag, "_busy"},      32'(busy),      32'(0));
    endtask

    vec_t vt[19];
    exp_t ev;
    int   lat, bc;
    bit   seen;

    initial begin
        // {op, a, b, ans, {Z,N,C,V}, illegal}; dm_data is always b
        vt[0]  = '{OP_ADD,   8'hFF, 8'h01, 8'h00, 4'b1010, 1'b0};
        vt[1]  = '{OP_ADC,   8'h00, 8'h00, 8'h01, 4'b0000, 1'b0};
        vt[2]  = '{OP_SUB,   8'h80, 8'h01, 8'h7F, 4'b0011, 1'b0};
        vt[3]  = '{OP_SHR,   8'h81, 8'h01, 8'h40, 4'b0010, 1'b0};
        vt[4]  = '{OP_SRA,   8'h80, 8'h03, 8'hF0, 4'b0100, 1'b0};
        vt[5]  = '{OP_AND,   8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0};
        vt[6]  = '{OP_OR,    8'h00, 8'h00, 8'h00, 4'b1000, 1'b0};
        vt[7]  = '{OP_XOR,   8'hAA, 8'hFF, 8'h55, 4'b0000, 1'b0};
        vt[8]  = '{OP_NOT,   8'h0F, 8'h00, 8'hF0, 4'b0100, 1'b0};
        vt[9]  = '{OP_SHL,   8'h81, 8'h01, 8'h02, 4'b0010, 1'b0};
        vt[10] = '{OP_SHL,   8'h81, 8'h08, 8'h81, 4'b0100, 1'b0};
        vt[11] = '{OP_ADD,   8'h7F, 8'h01, 8'h80, 4'b0101, 1'b0};
        vt[12] = '{OP_STORE, 8'h34, 8'h77, 8'h34, 4'b0101, 1'b0};
        vt[13] = '{OP_PASS,  8'h12, 8'h00, 8'h00, 4'b1000, 1'b0};
        vt[14] = '{OP_BAD,   8'h33, 8'h5A, 8'h00, 4'b1000, 1'b1};
        vt[15] = '{OP_SUB,   8'h01, 8'h02, 8'hFF, 4'b0100, 1'b0};
`ifdef EXEC_MUL_EN
        vt[16] = '{OP_MUL,   8'h03, 8'h05, 8'h0F, 4'b0000, 1'b0};
`else
        vt[16] = '{OP_MUL,   8'h03, 8'h05, 8'h00, 4'b0100, 1'b1};
`endif
        vt[17] = '{OP_ADD,   8'h80, 8'h80, 8'h00, 4'b1011, 1'b0};
        vt[18] = '{OP_ADC,   8'h10, 8'h20, 8'h31, 4'b0000, 1'b0};

        reset = 1'b1; in_valid = 1'b0; op_dec = '0; a = '0; b = '0; out_ready = 1'b1;
        @(negedge clk);
        chk_all_zero("rst");
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        #2 reset = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset between edges while a result is being held
        out_ready = 1'b0;
        send(OP_ADD, 8'h11, 8'h22, '0, 1'b0);
        chk("pre_rst_valid", 32'(out_valid), 32'(1));
        chk("pre_rst_ans",   32'(ans_ex),    32'(8'h33));
        #3 reset = 1'b1;
        #1 chk_all_zero("async_rst");
        @(negedge clk); #2 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk); #1 out_ready = 1'b1;

        // Table, issued back to back
        for (int i = 0; i < 19; i++) begin
            ev.ans = vt[i].ans; ev.dm = vt[i].b; ev.fl = vt[i].fl; ev.ill = vt[i].ill;
            send(vt[i].op, vt[i].a, vt[i].b, ev, 1'b1);
        end
        repeat (3) @(posedge clk);
        #1 chk("table_drain", 32'(sbq.size()), 32'(0));

        // Back-pressure: first result held, two more queued behind it
        out_ready = 1'b0;
        send(OP_ADD, 8'h01, 8'h01, '{8'h02, 8'h01, 4'b0000, 1'b0}, 1'b1);
        fork
            begin
                send(OP_ADD, 8'h02, 8'h03, '{8'h05, 8'h03, 4'b0000, 1'b0}, 1'b1);
                send(OP_ADD, 8'h04, 8'h04, '{8'h08, 8'h04, 4'b0000, 1'b0}, 1'b1);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(in_ready),  32'(0));
                    chk("bp_valid",    32'(out_valid), 32'(1));
                    chk("bp_hold_ans", 32'(ans_ex),    32'(8'h02));
                    chk("bp_hold_dm",  32'(dm_data),   32'(8'h01));
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1 chk("bp_drain", 32'(sbq.size()), 32'(0));

`ifdef EXEC_MUL_EN
        // Latency counted in edges after the accepting edge: WIDTH+1 cycles from accept => WIDTH edges
        send(OP_MUL, 8'h12, 8'h10, '{8'h20, 8'h10, 4'b0011, 1'b0}, 1'b1);
        bc = busy ? 1 : 0; lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bc++;
        end
        chk("mul_latency", 32'(lat), 32'(W));
        chk("mul_busy_cycles", 32'(bc), 32'(W));
        send(OP_MUL, 8'h0F, 8'h11, '{8'hFF, 8'h11, 4'b0100, 1'b0}, 1'b1);
        repeat (W + 3) @(posedge clk);
        #1 chk("mul_drain", 32'(sbq.size()), 32'(0));

        // Reset in the middle of a multiply discards it
        send(OP_MUL, 8'h05, 8'h05, '0, 1'b0);
        repeat (3) @(posedge clk);
        #3 chk("mul_busy_mid", 32'(busy), 32'(1));
        reset = 1'b1;
        #1 chk("mul_rst_busy", 32'(busy), 32'(0));
        chk("mul_rst_valid", 32'(out_valid), 32'(0));
        @(negedge clk); #2 reset = 1'b0;
        seen = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("mul_rst_no_result", 32'(seen), 32'(0));
        chk("mul_rst_in_ready", 32'(in_ready), 32'(1));
`else
        chk("busy_never", 32'(busy_cyc), 32'(0));
`endif

        chk("sb_empty", 32'(sbq.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
